// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Round-robin arbiter that merges writeback sources onto the single
//            register-file write port, with a registered output and bypass.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_addr,
    input  logic [XLEN*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rd_we,
    output logic [4:0]              rd_addr,
    output logic [XLEN-1:0]         rd_data,
    output logic [GW-1:0]           grant_id,
    input  logic [4:0]              byp_addr,
    output logic                    byp_hit,
    output logic [XLEN-1:0]         byp_data
);

    localparam logic [GW-1:0] C_LAST_RST = GW'(NUM_REQ - 1);

    logic [4:0]      w_addr [NUM_REQ];
    logic [XLEN-1:0] w_data [NUM_REQ];

    logic [GW-1:0]   last_q,    last_d;
    logic [GW-1:0]   grant_q,   grant_d;
    logic            rd_we_q,   rd_we_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic            w_win_valid;
    logic [GW-1:0]   w_win_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr[gi] = req_addr[5*gi +: 5];
        assign w_data[gi] = req_data[XLEN*gi +: XLEN];
    end

    // Scan starts just past the last winner, so the last winner ranks lowest.
    always_comb begin
        logic [GW-1:0] cand;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % NUM_REQ);
            if (!w_win_valid && req_valid[cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_win_valid && !rst) begin
            req_ready[w_win_idx] = 1'b1;
        end
    end

    always_comb begin
        last_d    = last_q;
        grant_d   = grant_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rd_we_d   = 1'b0;
        if (w_win_valid) begin
            last_d    = w_win_idx;
            grant_d   = w_win_idx;
            rd_addr_d = w_addr[w_win_idx];
            rd_data_d = w_data[w_win_idx];
            // x0 writes complete the handshake but never reach the regfile
            rd_we_d   = (w_addr[w_win_idx] != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= C_LAST_RST;
            grant_q   <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            last_q    <= last_d;
            grant_q   <= grant_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_we    = rd_we_q;
    assign rd_addr  = rd_addr_q;
    assign rd_data  = rd_data_q;
    assign grant_id = grant_q;
    assign byp_hit  = rd_we_q && (rd_addr_q == byp_addr) && (byp_addr != 5'd0);
    assign byp_data = rd_data_q;

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates several writeback sources (ALU, load/store unit, CSR unit) onto the single write port of the 32×32 integer register file. Uses round-robin fairness and a valid/ready handshake per requester. The granted write is registered for one cycle before it drives the register file's write-enable, write-address and write-data inputs. A bypass lookup against the registered write lets the decode stage forward data written in the same cycle.

## Interface

- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- GW, $clog2(NUM_REQ), width of grant index

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  bit i: requester i presents a write
- req_addr  in  5*NUM_REQ  flattened destination register; slice i = [5*i+4:5*i]
- req_data  in  XLEN*NUM_REQ  flattened write data; slice i = [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NUM_REQ  one-hot or zero; bit i: requester i accepted this cycle
- rd_we  out  1  register-file write enable (registered)
- rd_addr  out  5  register-file write address (registered)
- rd_data  out  XLEN  register-file write data (registered)
- grant_id  out  GW  index of requester whose write is on rd_*
- byp_addr  in  5  register address queried by decode
- byp_hit  out  1  rd_we && rd_addr == byp_addr && byp_addr != 0 (combinational)
- byp_data  out  XLEN  equals rd_data; meaningful only when byp_hit

## Operation

- State:
  - round-robin pointer `last` (GW bits), reset NUM_REQ-1, so requester 0 has first priority after reset
  - output register {rd_we, rd_addr, rd_data, grant_id}
- Arbitration (combinational):
  - Search order is last+1, last+2, … modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i]=1 for the winner only; all zero when no requester is valid.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Acceptance: a transfer occurs when req_valid[i] && req_ready[i]. Exactly zero or one transfer per cycle.
- On transfer, at the next clock edge:
  - last <= i
  - grant_id <= i
  - rd_addr <= req_addr slice i
  - rd_data <= req_data slice i
  - rd_we <= (req_addr slice i != 0)
- x0 writes are accepted (handshake completes, pointer advances) but produce rd_we=0. rd_addr/rd_data still load.
- No transfer: rd_we <= 0. last, rd_addr, rd_data and grant_id hold their values.
- Downstream never back-pressures; the register-file write port accepts every cycle.
- Requester obligations: hold req_valid, req_addr and req_data stable until accepted. The arbiter does not check this.
- Reset (any time, including mid-transfer):
  - rd_we=0, rd_addr=0, rd_data=0, grant_id=0, last=NUM_REQ-1
  - req_ready is forced to 0 while rst=1
  - a write in the output register at reset assertion is lost

## Timing

- Latency: accept in cycle N; rd_we/rd_addr/rd_data are valid in cycle N+1; the register file updates at the end of N+1.
- Throughput: one write per cycle, sustained.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…
  - A waiting requester is granted within NUM_REQ cycles.
- Simultaneous new request and pointer update: arbitration in cycle N uses the value of last from before the cycle-N edge.
- Bypass: byp_hit/byp_data reflect the output register in the same cycle, with no added latency. The register file's own read path sees the new value only from N+2.
- Release of rst is synchronous to clk: the first arbitration happens on the first clk edge after deassertion.

## Test plan

- Reset: rst=1 mid-stream with requesters valid → req_ready=0, rd_we=0, rd_addr=0, rd_data=0, grant_id=0. After release, req_valid=3'b111 → req_ready=3'b001 first.
- Single requester: requester 1 presents addr=5, data=32'hDEADBEEF, valid for one cycle → req_ready=3'b010 that cycle; next cycle rd_we=1, rd_addr=5, rd_data=32'hDEADBEEF, grant_id=1; following cycle rd_we=0.
- Round-robin: all three valid for 6 cycles with distinct addresses → grant_id sequence 0,1,2,0,1,2 on rd_* one cycle delayed; each requester sees exactly 2 ready pulses.
- x0 drop: requester 2 writes addr=0, data=32'h1234 → req_ready[2]=1, next cycle rd_we=0. Then requesters 0 and 2 are both valid → requester 0 is granted, because the pointer advanced to 2.
- Bypass: accept a write to addr=7, data=32'hA5A5A5A5; in the rd_we cycle set byp_addr=7 → byp_hit=1, byp_data=32'hA5A5A5A5. byp_addr=8 → byp_hit=0. A write to 0 with byp_addr=0 → byp_hit=0.
- Back-to-back contention: requester 0 valid every cycle, requester 1 joins at cycle 3 → requester 1 is granted at cycle 3 or 4, never starved beyond NUM_REQ cycles.
